// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gray_pkg
// Description : Shared constants and Gray/binary helper functions for the
//               Gray-code counter family. The helpers work on the maximum
//               width; narrower values are zero-extended in and truncated out.
//               Leading zeros do not change either mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package gray_pkg;

  localparam int GRAY_MAX_WIDTH = 32;

  // Binary to Gray: each Gray bit is the XOR of adjacent binary bits.
  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(
    input logic [GRAY_MAX_WIDTH-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(
    input logic [GRAY_MAX_WIDTH-1:0] g
  );
    logic [GRAY_MAX_WIDTH-1:0] b;
    b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gray2bin_conv.sv
`default_nettype none
// ============================================================================
// Module      : gray2bin_conv
// Description : Purely combinational WIDTH-bit Gray-to-binary converter.
//               Generalised successor of the fixed 4-bit converter; usable
//               standalone.
// Revision    : 1.0 - initial release
// ============================================================================
module gray2bin_conv #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  // Each binary bit is the reduction XOR of the Gray bits from MSB down to it.
  // Written as a per-bit reduction rather than a ripple chain so that no
  // vector feeds back into itself.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[WIDTH-1:i];
  end

endmodule
`default_nettype wire

// File: rtl/gray_counter.sv
`default_nettype none
// ============================================================================
// Module      : gray_counter
// Description : Registered Gray-code up/down counter with Gray-coded load,
//               simultaneous registered Gray and binary views, and a one-cycle
//               wrap pulse. A binary register is the master state; the Gray
//               register is loaded from the same next value on the same edge.
// Options     : GRAY_COUNTER_SAT_EN - when defined, counting saturates at the
//               ends of the range and wrap flags every blocked step.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_counter
  import gray_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] c_RST_GRAY = RST_VAL ^ (RST_VAL >> 1);
  localparam logic [WIDTH-1:0] c_ONE      = WIDTH'(1);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;

  logic [WIDTH-1:0] w_load_bin;
  logic [WIDTH-1:0] w_next_cnt;
  logic [WIDTH-1:0] w_next_gray;
  logic             w_next_wrap;
  logic             w_at_max;
  logic             w_at_min;

  gray2bin_conv #(
    .WIDTH (WIDTH)
  ) u_load_conv (
    .i_gray (load_gray),
    .o_bin  (w_load_bin)
  );

  assign w_at_max = &r_cnt;
  assign w_at_min = ~|r_cnt;

  // Next count and wrap flag: load beats counting, counting beats hold.
  always_comb begin
    w_next_cnt  = r_cnt;
    w_next_wrap = 1'b0;
    if (load) begin
      w_next_cnt = w_load_bin;
    end else if (en) begin
      if (up_dn) begin
`ifdef GRAY_COUNTER_SAT_EN
        w_next_cnt  = w_at_max ? r_cnt : r_cnt + c_ONE;
`else
        w_next_cnt  = r_cnt + c_ONE;
`endif
        w_next_wrap = w_at_max;
      end else begin
`ifdef GRAY_COUNTER_SAT_EN
        w_next_cnt  = w_at_min ? r_cnt : r_cnt - c_ONE;
`else
        w_next_cnt  = r_cnt - c_ONE;
`endif
        w_next_wrap = w_at_min;
      end
    end
  end

  // Gray view derived from the next binary value so both registers agree.
  assign w_next_gray = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(w_next_cnt)));

  // State registers with asynchronous reset to the configured start value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= RST_VAL;
      r_gray <= c_RST_GRAY;
      r_wrap <= 1'b0;
    end else begin
      r_cnt  <= w_next_cnt;
      r_gray <= w_next_gray;
      r_wrap <= w_next_wrap;
    end
  end

  assign bin_out  = r_cnt;
  assign gray_out = r_gray;
  assign wrap     = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_gray_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_counter
// Description : Directed self-checking bench for gray_counter. One 4-bit
//               instance with RST_VAL=0 and one 8-bit instance with
//               RST_VAL=8'hFE. Expected values are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_counter;

  logic       clk;
  // 4-bit instance
  logic       rst, en, up_dn, load;
  logic [3:0] load_gray, gray_out, bin_out;
  logic       wrap;
  // 8-bit instance
  logic       rst2, en2, up_dn2, load2;
  logic [7:0] load_gray2, gray_out2, bin_out2;
  logic       wrap2;

  int n_chk  = 0;
  int n_fail = 0;

  gray_counter #(.WIDTH(4), .RST_VAL(4'd0)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .up_dn     (up_dn),
    .load      (load),
    .load_gray (load_gray),
    .gray_out  (gray_out),
    .bin_out   (bin_out),
    .wrap      (wrap)
  );

  gray_counter #(.WIDTH(8), .RST_VAL(8'hFE)) u_dut8 (
    .clk       (clk),
    .rst       (rst2),
    .en        (en2),
    .up_dn     (up_dn2),
    .load      (load2),
    .load_gray (load_gray2),
    .gray_out  (gray_out2),
    .bin_out   (bin_out2),
    .wrap      (wrap2)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Gray codes of binary 1..15, then 0 (wrap), for the 4-bit up sweep.
  logic [3:0] up_gray [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                               4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
  logic [3:0] prev_gray;

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_gray = 4'h0;
    rst2 = 1'b1; en2 = 1'b0; up_dn2 = 1'b1; load2 = 1'b0; load_gray2 = 8'h00;

    // Reset state, visible before any clock edge.
    #3;
    chk("rst_bin", 32'(bin_out), 32'h0);
    chk("rst_gray", 32'(gray_out), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    chk("rst8_bin", 32'(bin_out2), 32'hFE);
    chk("rst8_gray", 32'(gray_out2), 32'h81);
    chk("rst8_wrap", 32'(wrap2), 32'h0);

    // Release reset between edges and count up for 16 cycles.
    #9;
    rst = 1'b0; rst2 = 1'b0;
    en = 1'b1; up_dn = 1'b1;
    prev_gray = gray_out;
    for (int k = 1; k <= 16; k++) begin
      step();
`ifdef GRAY_COUNTER_SAT_EN
      if (k == 16) begin
        chk("up16_sat_gray", 32'(gray_out), 32'h8);
        chk("up16_sat_bin", 32'(bin_out), 32'hF);
        chk("up16_sat_wrap", 32'(wrap), 32'h1);
      end else begin
`else
      begin
`endif
        chk($sformatf("up%0d_gray", k), 32'(gray_out), 32'(up_gray[k-1]));
        chk($sformatf("up%0d_bin", k), 32'(bin_out), 32'(k % 16));
        chk($sformatf("up%0d_wrap", k), 32'(wrap), (k == 16) ? 32'h1 : 32'h0);
        chk($sformatf("up%0d_onebit", k), 32'($countones(gray_out ^ prev_gray)), 32'h1);
      end
      prev_gray = gray_out;
    end
    // The 8-bit instance was idle with en2=0 and must still hold its reset value.
    chk("idle8_bin", 32'(bin_out2), 32'hFE);

    // Load beats a simultaneous count-down request.
    load = 1'b1; load_gray = 4'b1101; en = 1'b1; up_dn = 1'b0;
    step();
    chk("load_bin", 32'(bin_out), 32'h9);
    chk("load_gray", 32'(gray_out), 32'hD);
    chk("load_wrap", 32'(wrap), 32'h0);

    // Load zero, then count down through the bottom.
    load_gray = 4'h0;
    step();
    chk("load0_bin", 32'(bin_out), 32'h0);
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    step();
`ifdef GRAY_COUNTER_SAT_EN
    chk("dn_sat1_bin", 32'(bin_out), 32'h0);
    chk("dn_sat1_gray", 32'(gray_out), 32'h0);
    chk("dn_sat1_wrap", 32'(wrap), 32'h1);
    step();
    chk("dn_sat2_bin", 32'(bin_out), 32'h0);
    chk("dn_sat2_wrap", 32'(wrap), 32'h1);
`else
    chk("dn_wrap_bin", 32'(bin_out), 32'hF);
    chk("dn_wrap_gray", 32'(gray_out), 32'h8);
    chk("dn_wrap_wrap", 32'(wrap), 32'h1);
    step();
    chk("dn_next_bin", 32'(bin_out), 32'hE);
    chk("dn_next_gray", 32'(gray_out), 32'h9);
    chk("dn_next_wrap", 32'(wrap), 32'h0);
`endif

    // Direction change: load 5 (Gray 0111), down twice, then up once.
    load = 1'b1; load_gray = 4'b0111; en = 1'b0;
    step();
    chk("load5_bin", 32'(bin_out), 32'h5);
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    step();
    chk("rev_dn1_bin", 32'(bin_out), 32'h4);
    chk("rev_dn1_gray", 32'(gray_out), 32'h6);
    step();
    chk("rev_dn2_bin", 32'(bin_out), 32'h3);
    chk("rev_dn2_gray", 32'(gray_out), 32'h2);
    up_dn = 1'b1;
    step();
    chk("rev_up_bin", 32'(bin_out), 32'h4);
    chk("rev_up_gray", 32'(gray_out), 32'h6);

    // Hold with en=0.
    en = 1'b0;
    step();
    chk("hold_bin", 32'(bin_out), 32'h4);
    chk("hold_wrap", 32'(wrap), 32'h0);

    // Asynchronous reset mid-cycle while counting from 7 (Gray 0100).
    load = 1'b1; load_gray = 4'b0100;
    step();
    chk("load7_bin", 32'(bin_out), 32'h7);
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_bin", 32'(bin_out), 32'h0);
    chk("arst_gray", 32'(gray_out), 32'h0);
    chk("arst_wrap", 32'(wrap), 32'h0);
    step();
    chk("arst_held_bin", 32'(bin_out), 32'h0);
    #3;
    rst = 1'b0;
    step();
    chk("after_rst_bin", 32'(bin_out), 32'h1);
    chk("after_rst_gray", 32'(gray_out), 32'h1);
    en = 1'b0;

    // 8-bit instance from FE: count up three cycles through the top.
    en2 = 1'b1; up_dn2 = 1'b1;
    step();
    chk("w8_s1_bin", 32'(bin_out2), 32'hFF);
    chk("w8_s1_gray", 32'(gray_out2), 32'h80);
    chk("w8_s1_wrap", 32'(wrap2), 32'h0);
    step();
`ifdef GRAY_COUNTER_SAT_EN
    chk("w8_s2_bin", 32'(bin_out2), 32'hFF);
    chk("w8_s2_gray", 32'(gray_out2), 32'h80);
    chk("w8_s2_wrap", 32'(wrap2), 32'h1);
    step();
    chk("w8_s3_bin", 32'(bin_out2), 32'hFF);
    chk("w8_s3_wrap", 32'(wrap2), 32'h1);
`else
    chk("w8_s2_bin", 32'(bin_out2), 32'h00);
    chk("w8_s2_gray", 32'(gray_out2), 32'h00);
    chk("w8_s2_wrap", 32'(wrap2), 32'h1);
    step();
    chk("w8_s3_bin", 32'(bin_out2), 32'h01);
    chk("w8_s3_gray", 32'(gray_out2), 32'h01);
    chk("w8_s3_wrap", 32'(wrap2), 32'h0);
`endif
    en2 = 1'b0;

    // 8-bit load: Gray 8'hA5 is binary 8'hC6.
    load2 = 1'b1; load_gray2 = 8'hA5;
    step();
    chk("w8_load_bin", 32'(bin_out2), 32'hC6);
    chk("w8_load_gray", 32'(gray_out2), 32'hA5);
    load2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute watchdog so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
